imm_ext_queue: RTL and testbench
================================

// Module: imm_ext_queue
// PURPOSE
//  Parametrised immediate-extension unit with a registered, flow-controlled output queue.
//  Extends an IN_W-bit instruction immediate to OUT_W bits in one of four modes: sign, zero, upper/LUI, branch-offset.
//  Sits between instruction decode and ALU-source mux of the multi-cycle MIPS datapath.
//  Decouples decode from execute via valid/ready handshake and a DEPTH-entry FIFO.
// PARAMETERS
//  IN_W   16  immediate width; 1 <= IN_W < OUT_W
//  OUT_W  32  extended result width
//  SHIFT  2   left shift applied in branch mode; 0 <= SHIFT < OUT_W
//  DEPTH  4   queue entries; power of two, >= 2
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      producer presents imm/mode
//  in_ready   out  1      queue can accept this cycle
//  in_imm     in   IN_W   raw immediate field
//  in_mode    in   2      00 sign, 01 zero, 10 upper, 11 branch
//  out_valid  out  1      head entry valid
//  out_ready  in   1      consumer takes head this cycle
//  out_data   out  OUT_W  extended value at queue head
//  count      out  $clog2(DEPTH)+1  current occupancy
//  acc_cnt    out  16     accepted-transfer counter (see CONFIGURATION)
// BEHAVIOUR
//  Extension (combinational, computed at write):
//   - 00 sign:   {{(OUT_W-IN_W){imm[IN_W-1]}}, imm}
//   - 01 zero:   {{(OUT_W-IN_W){1'b0}}, imm}
//   - 10 upper:  imm << (OUT_W-IN_W); low bits zero (LUI when 16/32)
//   - 11 branch: sign-extended value << SHIFT, truncated to OUT_W bits
//  Handshake:
//   - push = in_valid & in_ready; pop = out_valid & out_ready
//   - in_ready = (count < DEPTH); no same-cycle pass-through when full
//   - out_valid = (count != 0); out_data = mem[rd_ptr]; held stable while out_valid & !out_ready
//   - latency: entry pushed at edge N is visible on out_data/out_valid after edge N (1 cycle)
//  Pointers/count:
//   - wr_ptr, rd_ptr are $clog2(DEPTH) bits, wrap modulo DEPTH naturally
//   - push only: count+1; pop only: count-1; push&pop: count unchanged, both pointers advance
//   - push&pop legal only when 0 < count < DEPTH (in_ready gates push at full; out_valid gates pop at empty)
//   - empty + push: out_valid rises next cycle; out_ready ignored while empty
//   - in_mode/in_imm ignored when push=0
//  Reset (synchronous, priority over push/pop):
//   - wr_ptr=0, rd_ptr=0, count=0, out_valid=0, in_ready=1, acc_cnt=0
//   - reset mid-operation discards all entries; out_data is don't-care while out_valid=0
//   - storage array is not cleared
// CONFIGURATION
//  Macro IMM_EXT_STATS_EN:
//   - defined: acc_cnt increments on every push, wraps 0xFFFF->0x0000, cleared by reset
//   - undefined: acc_cnt tied to 16'h0000; no counter flops synthesised
//   - queue behaviour is identical with or without the macro
// TESTING (IN_W=16, OUT_W=32, SHIFT=2, DEPTH=4)
//  - Modes, out_ready=1: imm 0x8000 sign->0xFFFF8000, zero->0x00008000; 0x1234 upper->0x12340000; 0xFFFF branch->0xFFFFFFFC; 0x0001 branch->0x00000004
//  - Fill: out_ready=0, 5 back-to-back pushes -> in_ready=0 after 4th, count=4, 5th not accepted; then out_ready=1 -> 4 values out in order, count=0
//  - Simultaneous: count=2, push+pop same cycle -> count stays 2, FIFO order preserved across wrap-around (run >= 2*DEPTH transfers)
//  - Backpressure: out_valid=1 & out_ready=0 for 3 cycles -> out_data unchanged each cycle
//  - Reset mid-stream: count=3, assert reset 1 cycle -> next cycle count=0, out_valid=0, in_ready=1; first later push emerges first
//  - Stats (IMM_EXT_STATS_EN): 0x10000 pushes -> acc_cnt wraps to 0x0000; without macro acc_cnt stays 0

Source files
------------

// File: rtl/imm_ext_queue.sv
// rtl/imm_ext_queue.sv - immediate extension unit feeding a registered valid/ready output queue
// Optional feature macro: IMM_EXT_STATS_EN (enables the accepted-push counter on acc_cnt)

module imm_ext_queue #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          in_imm,
  input  logic [1:0]               in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              acc_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int EXT_W = OUT_W - IN_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] MODE_SIGN   = 2'b00;
  localparam logic [1:0] MODE_ZERO   = 2'b01;
  localparam logic [1:0] MODE_UPPER  = 2'b10;
  localparam logic [1:0] MODE_BRANCH = 2'b11;

  // Entry storage; deliberately has no reset so it maps onto plain RAM/flops.
  logic [OUT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_upper;
  logic [OUT_W-1:0] w_branch;
  logic [OUT_W-1:0] w_ext;

  // Candidate extensions; the immediate fully fits in the upper form because IN_W < OUT_W.
  assign w_sext   = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
  assign w_zext   = {{EXT_W{1'b0}}, in_imm};
  assign w_upper  = {in_imm, {EXT_W{1'b0}}};
  assign w_branch = w_sext << SHIFT;

  // Pick the extension requested by the decoder; only consumed when a push happens.
  always_comb begin
    w_ext = w_sext;
    case (in_mode)
      MODE_SIGN:   w_ext = w_sext;
      MODE_ZERO:   w_ext = w_zext;
      MODE_UPPER:  w_ext = w_upper;
      MODE_BRANCH: w_ext = w_branch;
      default:     w_ext = w_sext;
    endcase
  end

  // Occupancy flags derive straight from the count register, so no pass-through when full.
  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign w_push    = in_valid && !w_full;
  assign w_pop     = out_ready && !w_empty;
  assign out_data  = r_mem[r_rd_ptr];
  assign count     = r_count;

  // Write the extended value into the slot addressed by the write pointer.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_ext;
    end
  end

  // Pointer and occupancy bookkeeping; reset discards every queued entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef IMM_EXT_STATS_EN
  logic [15:0] r_acc_cnt;

  // Count accepted pushes; the 16-bit register wraps on its own.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc_cnt <= 16'h0000;
    end else if (w_push) begin
      r_acc_cnt <= r_acc_cnt + 16'd1;
    end
  end

  assign acc_cnt = r_acc_cnt;
`else
  assign acc_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_imm_ext_queue.sv
// tb/tb_imm_ext_queue.sv - self-checking bench for imm_ext_queue with a queue-based reference model

module tb_imm_ext_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  count;
  logic [15:0] acc_cnt;

  int checks;
  int failures;
  int pushes;
  logic [31:0] model_q[$];

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  imm_ext_queue #(.IN_W(16), .OUT_W(32), .SHIFT(2), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .acc_cnt   (acc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Reference extension computed with plain integer arithmetic.
  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    longint u;
    longint s;
    longint r;
    u = longint'(imm);
    s = (u >= 32768) ? u - 65536 : u;
    case (mode)
      2'd0:    r = s;
      2'd1:    r = u;
      2'd2:    r = u * 65536;
      default: r = s * 4;
    endcase
    return r[31:0];
  endfunction

  function automatic logic [15:0] exp_acc();
`ifdef IMM_EXT_STATS_EN
    return 16'(pushes);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic check_state();
    chk("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(model_q.size() < DEPTH));
    chk("count", 32'(count), 32'(model_q.size()));
    chk("acc_cnt", 32'(acc_cnt), 32'(exp_acc()));
    if (model_q.size() != 0) chk("out_data", out_data, model_q[0]);
  endtask

  // One clock: drive at negedge, check before the edge, update model at the edge.
  task automatic cycle(input logic v, input logic [15:0] imm, input logic [1:0] mode, input logic ordy);
    logic do_push;
    logic do_pop;
    in_valid  = v;
    in_imm    = imm;
    in_mode   = mode;
    out_ready = ordy;
    #1;
    check_state();
    do_push = v && (model_q.size() < DEPTH);
    do_pop  = ordy && (model_q.size() != 0);
    @(posedge clk);
    if (do_pop) void'(model_q.pop_front());
    if (do_push) begin
      model_q.push_back(ref_ext(imm, mode));
      pushes++;
    end
    @(negedge clk);
  endtask

  // Single-cycle reset with a push request present, to confirm reset priority.
  task automatic do_reset();
    in_valid  = 1'b1;
    in_imm    = 16'($urandom);
    in_mode   = 2'($urandom);
    out_ready = 1'b1;
    reset     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    model_q.delete();
    pushes = 0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_acc_cnt", 32'(acc_cnt), 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 16'h0000, 2'b00, 1'b1);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    pushes    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_imm    = 16'h0000;
    in_mode   = 2'b00;
    out_ready = 1'b0;

    vecs[0] = '{imm: 16'h8000, mode: 2'b00, exp: 32'hFFFF8000};
    vecs[1] = '{imm: 16'h8000, mode: 2'b01, exp: 32'h00008000};
    vecs[2] = '{imm: 16'h1234, mode: 2'b10, exp: 32'h12340000};
    vecs[3] = '{imm: 16'hFFFF, mode: 2'b11, exp: 32'hFFFFFFFC};
    vecs[4] = '{imm: 16'h0001, mode: 2'b11, exp: 32'h00000004};
    vecs[5] = '{imm: 16'h7FFF, mode: 2'b00, exp: 32'h00007FFF};
    vecs[6] = '{imm: 16'hFFFF, mode: 2'b01, exp: 32'h0000FFFF};
    vecs[7] = '{imm: 16'h8000, mode: 2'b11, exp: 32'hFFFE0000};
    vecs[8] = '{imm: 16'hABCD, mode: 2'b10, exp: 32'hABCD0000};

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_acc_cnt", 32'(acc_cnt), 32'd0);

    // Extension modes with out_ready held high: one entry in flight at a time.
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, vecs[i].imm, vecs[i].mode, 1'b1);
      chk("mode_data", out_data, vecs[i].exp);
      chk("mode_count", 32'(count), 32'd1);
    end
    drain();

    // Fill past capacity, then drain in order.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 16'(i + 1), 2'b01, 1'b0);
      if (i == 3) begin
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_count4", 32'(count), 32'd4);
      end
    end
    chk("fill_5th_dropped", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("fill_order", out_data, 32'(i + 1));
      cycle(1'b0, 16'h0000, 2'b00, 1'b1);
    end
    chk("fill_empty", 32'(count), 32'd0);

    // Simultaneous push and pop at count=2 across several pointer wraps.
    cycle(1'b1, 16'h0050, 2'b00, 1'b0);
    cycle(1'b1, 16'h0051, 2'b00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 16'(16'h0100 + i), 2'b00, 1'b1);
      chk("simul_count", 32'(count), 32'd2);
    end
    drain();

    // Backpressure: head must hold while the consumer stalls.
    cycle(1'b1, 16'h0ABC, 2'b11, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 16'h0000, 2'b00, 1'b0);
      chk("bp_hold", out_data, 32'h00002AF0);
      chk("bp_valid", 32'(out_valid), 32'd1);
    end
    drain();

    // Reset with three entries queued; a later push must come out first.
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'(16'h0200 + i), 2'b01, 1'b0);
    chk("mid_count3", 32'(count), 32'd3);
    do_reset();
    cycle(1'b1, 16'h0042, 2'b01, 1'b0);
    chk("post_reset_head", out_data, 32'h00000042);
    chk("post_reset_count", 32'(count), 32'd1);
    drain();

    // Randomized traffic against the reference model, with occasional resets.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 3) != 0, 16'($urandom), 2'($urandom), $urandom_range(0, 2) != 0);
      end
    end
    drain();

`ifdef IMM_EXT_STATS_EN
    // Counter wrap: 0x10000 accepted pushes return acc_cnt to zero.
    do_reset();
    in_valid  = 1'b1;
    in_imm    = 16'h0000;
    in_mode   = 2'b00;
    out_ready = 1'b1;
    repeat (65535) @(posedge clk);
    @(negedge clk);
    chk("acc_ffff", 32'(acc_cnt), 32'h0000FFFF);
    @(posedge clk);
    @(negedge clk);
    chk("acc_wrap", 32'(acc_cnt), 32'h00000000);
    in_valid = 1'b0;
    do_reset();
`else
    chk("acc_tied_zero", 32'(acc_cnt), 32'h00000000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
